digit_entry: RTL and testbench

DIGIT_ENTRY -- requirements
Module: digit_entry

---
 rtl/digit_entry_pkg.sv | 18 +
 rtl/digit_entry_if.sv | 21 ++
 rtl/digit_entry_hexseg.sv | 12 +
 rtl/digit_entry.sv | 139 +++++++++++++
 tb/tb_digit_entry.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the hex keypad digit-entry block.
package digit_entry_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } key_state_t;

    localparam int MAXDIG   = 8;
    localparam int DEBOUNCE = 3;

    // Segment patterns, bit0=a .. bit6=g, bit7=dp (always clear here)
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage

// File: rtl/digit_entry_if.sv
// Keypad inputs and display/value outputs of the digit-entry block.
interface digit_entry_if;
    logic [3:0]  code;
    logic        strobe;
    logic        bksp;
    logic        clr;
    logic [31:0] value;
    logic [3:0]  ndigits;
    logic        err;
    logic [7:0]  ss0, ss1, ss2, ss3, ss4, ss5, ss6, ss7;

    modport master (
        output code, strobe, bksp, clr,
        input  value, ndigits, err, ss0, ss1, ss2, ss3, ss4, ss5, ss6, ss7
    );

    modport slave (
        input  code, strobe, bksp, clr,
        output value, ndigits, err, ss0, ss1, ss2, ss3, ss4, ss5, ss6, ss7
    );
endinterface

// File: rtl/digit_entry_hexseg.sv
// Hex digit to seven-segment pattern; decimal point always off.
import digit_entry_pkg::*;

module hexseg (
    input  logic [3:0] digit,
    output logic [7:0] seg
);
    logic [7:0] pattern;

    assign pattern = SEG_TABLE[digit];
    assign seg     = {1'b0, pattern[6:0]};
endmodule

// File: rtl/digit_entry.sv
// Keypad digit entry: synchronizes buttons, debounces digit presses and
// maintains an 8-digit hex number with backspace, clear and overflow flag.
import digit_entry_pkg::*;

module digit_entry (
    input  logic        hz100,
    input  logic        reset,
    input  logic [3:0]  code,
    input  logic        strobe,
    input  logic        bksp,
    input  logic        clr,
    output logic [31:0] value,
    output logic [3:0]  ndigits,
    output logic        err,
    output logic [7:0]  ss7,
    output logic [7:0]  ss6,
    output logic [7:0]  ss5,
    output logic [7:0]  ss4,
    output logic [7:0]  ss3,
    output logic [7:0]  ss2,
    output logic [7:0]  ss1,
    output logic [7:0]  ss0
);
    logic        strobe_meta_reg, strobe_sync_reg;
    logic [3:0]  code_meta_reg, code_sync_reg;
    logic        bksp_meta_reg, bksp_sync_reg, bksp_prev_reg;
    logic        clr_meta_reg, clr_sync_reg, clr_prev_reg;
    key_state_t  state_reg;
    logic [1:0]  deb_cnt_reg;
    logic [31:0] value_reg;
    logic [3:0]  ndigits_reg;
    logic        err_reg;

    logic bksp_rise, clr_rise, digit_accept;

    assign bksp_rise    = bksp_sync_reg & ~bksp_prev_reg;
    assign clr_rise     = clr_sync_reg & ~clr_prev_reg;
    assign digit_accept = (state_reg == IDLE) && strobe_sync_reg;

    always_ff @(posedge hz100) begin
        if (reset) begin
            strobe_meta_reg <= 1'b0;
            strobe_sync_reg <= 1'b0;
            code_meta_reg   <= 4'h0;
            code_sync_reg   <= 4'h0;
            bksp_meta_reg   <= 1'b0;
            bksp_sync_reg   <= 1'b0;
            bksp_prev_reg   <= 1'b0;
            clr_meta_reg    <= 1'b0;
            clr_sync_reg    <= 1'b0;
            clr_prev_reg    <= 1'b0;
            state_reg       <= IDLE;
            deb_cnt_reg     <= 2'd0;
            value_reg       <= 32'h0;
            ndigits_reg     <= 4'd0;
            err_reg         <= 1'b0;
        end else begin
            strobe_meta_reg <= strobe;
            strobe_sync_reg <= strobe_meta_reg;
            code_meta_reg   <= code;
            code_sync_reg   <= code_meta_reg;
            bksp_meta_reg   <= bksp;
            bksp_sync_reg   <= bksp_meta_reg;
            bksp_prev_reg   <= bksp_sync_reg;
            clr_meta_reg    <= clr;
            clr_sync_reg    <= clr_meta_reg;
            clr_prev_reg    <= clr_sync_reg;

            // The key FSM advances even when a higher-priority button drops the digit
            case (state_reg)
                IDLE: begin
                    if (strobe_sync_reg) begin
                        state_reg   <= HELD;
                        deb_cnt_reg <= 2'd0;
                    end
                end
                HELD: begin
                    if (strobe_sync_reg) begin
                        deb_cnt_reg <= 2'd0;
                    end else if (deb_cnt_reg == 2'(DEBOUNCE - 1)) begin
                        state_reg   <= IDLE;
                        deb_cnt_reg <= 2'd0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 2'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (clr_rise) begin
                value_reg   <= 32'h0;
                ndigits_reg <= 4'd0;
                err_reg     <= 1'b0;
            end else if (bksp_rise) begin
                value_reg <= {4'h0, value_reg[31:4]};
                if (ndigits_reg != 4'd0)
                    ndigits_reg <= ndigits_reg - 4'd1;
                err_reg <= 1'b0;
            end else if (digit_accept) begin
                if (ndigits_reg < 4'(MAXDIG)) begin
                    value_reg   <= {value_reg[27:0], code_sync_reg};
                    ndigits_reg <= ndigits_reg + 4'd1;
                end else begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign value   = value_reg;
    assign ndigits = ndigits_reg;
    assign err     = err_reg;

    logic [7:0] seg [8];
    logic [7:0] ss  [8];

    // Unentered positions are blank; an empty entry still shows a single "0"
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        hexseg u_hexseg (
            .digit (value_reg[4*gi +: 4]),
            .seg   (seg[gi])
        );
        if (gi == 0) begin : g_first
            assign ss[gi] = ((ndigits_reg == 4'd0) ? SEG_TABLE[0] : seg[gi])
                          | {err_reg, 7'b0};
        end else begin : g_rest
            assign ss[gi] = (4'(gi) < ndigits_reg) ? seg[gi] : 8'h00;
        end
    end

    assign ss0 = ss[0];
    assign ss1 = ss[1];
    assign ss2 = ss[2];
    assign ss3 = ss[3];
    assign ss4 = ss[4];
    assign ss5 = ss[5];
    assign ss6 = ss[6];
    assign ss7 = ss[7];
endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry: directed scenarios plus randomized
// key sequences checked against a digit-list model of the entry.
`timescale 1ns/1ps
module tb_digit_entry;
    logic hz100 = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    digit_entry_if de ();

    digit_entry dut (
        .hz100   (hz100),
        .reset   (reset),
        .code    (de.code),
        .strobe  (de.strobe),
        .bksp    (de.bksp),
        .clr     (de.clr),
        .value   (de.value),
        .ndigits (de.ndigits),
        .err     (de.err),
        .ss7     (de.ss7),
        .ss6     (de.ss6),
        .ss5     (de.ss5),
        .ss4     (de.ss4),
        .ss3     (de.ss3),
        .ss2     (de.ss2),
        .ss1     (de.ss1),
        .ss0     (de.ss0)
    );

    always #5 hz100 = ~hz100;

    logic [7:0] ss_obs [8];
    assign ss_obs[0] = de.ss0;
    assign ss_obs[1] = de.ss1;
    assign ss_obs[2] = de.ss2;
    assign ss_obs[3] = de.ss3;
    assign ss_obs[4] = de.ss4;
    assign ss_obs[5] = de.ss5;
    assign ss_obs[6] = de.ss6;
    assign ss_obs[7] = de.ss7;

    // Model: entered digits oldest first, plus the overflow flag
    logic [3:0] q[$];
    logic       m_err;
    logic [7:0] seg_ref [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    function automatic void m_digit(logic [3:0] d);
        if (q.size() < 8) q.push_back(d);
        else m_err = 1'b1;
    endfunction

    function automatic void m_bksp();
        if (q.size() > 0) void'(q.pop_back());
        m_err = 1'b0;
    endfunction

    function automatic void m_clr();
        q.delete();
        m_err = 1'b0;
    endfunction

    function automatic logic [31:0] exp_value();
        logic [31:0] v = 32'h0;
        foreach (q[i]) v = {v[27:0], q[i]};
        return v;
    endfunction

    function automatic logic [7:0] exp_ss(int n);
        logic [7:0] s;
        int sz = q.size();
        if (n < sz) s = seg_ref[q[sz-1-n]];
        else if (n == 0) s = 8'h3F;
        else s = 8'h00;
        if (n == 0) s[7] = m_err;
        return s;
    endfunction

    task automatic press(logic [3:0] d, int hold, int rel);
        @(posedge hz100); #1;
        de.code = d; de.strobe = 1'b1;
        repeat (hold) @(posedge hz100);
        #1 de.strobe = 1'b0;
        repeat (rel) @(posedge hz100);
    endtask

    task automatic pulse_bksp(int hold);
        @(posedge hz100); #1 de.bksp = 1'b1;
        repeat (hold) @(posedge hz100);
        #1 de.bksp = 1'b0;
        repeat (5) @(posedge hz100);
    endtask

    task automatic pulse_clr(int hold);
        @(posedge hz100); #1 de.clr = 1'b1;
        repeat (hold) @(posedge hz100);
        #1 de.clr = 1'b0;
        repeat (5) @(posedge hz100);
    endtask

    task automatic test_reset();
        @(posedge hz100); #1;
        reset = 1'b1; de.code = 4'h0; de.strobe = 0; de.bksp = 0; de.clr = 0;
        repeat (3) @(posedge hz100);
        #1 reset = 1'b0;
        m_clr();
        @(negedge hz100);
        checks++; if (de.value !== 32'h0) begin failures++; $display("FAIL reset_value got=%h exp=0", de.value); end
        checks++; if (de.ndigits !== 4'd0) begin failures++; $display("FAIL reset_ndigits got=%0d exp=0", de.ndigits); end
        checks++; if (de.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", de.err); end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (ss_obs[n] !== exp_ss(n)) begin failures++; $display("FAIL reset_ss%0d got=%h exp=%h", n, ss_obs[n], exp_ss(n)); end
        end
        $display("txn reset value=%h ndigits=%0d", de.value, de.ndigits);
    endtask

    task automatic test_latency();
        @(posedge hz100); #1 de.code = 4'h1; de.strobe = 1'b1;
        @(posedge hz100);  // edge k
        @(negedge hz100);
        checks++; if (de.ndigits !== 4'd0) begin failures++; $display("FAIL lat_k got=%0d exp=0", de.ndigits); end
        @(posedge hz100);  // edge k+1
        @(negedge hz100);
        checks++; if (de.ndigits !== 4'd0) begin failures++; $display("FAIL lat_k1 got=%0d exp=0", de.ndigits); end
        @(posedge hz100);  // edge k+2
        @(negedge hz100);
        m_digit(4'h1);
        checks++; if (de.value !== exp_value()) begin failures++; $display("FAIL lat_value got=%h exp=%h", de.value, exp_value()); end
        checks++; if (de.ndigits !== 4'(q.size())) begin failures++; $display("FAIL lat_ndigits got=%0d exp=%0d", de.ndigits, q.size()); end
        repeat (7) @(posedge hz100);
        #1 de.strobe = 1'b0;
        repeat (6) @(posedge hz100);
        @(negedge hz100);
        checks++; if (de.value !== exp_value()) begin failures++; $display("FAIL held_value got=%h exp=%h", de.value, exp_value()); end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (ss_obs[n] !== exp_ss(n)) begin failures++; $display("FAIL lat_ss%0d got=%h exp=%h", n, ss_obs[n], exp_ss(n)); end
        end
        $display("txn press 1 value=%h ndigits=%0d", de.value, de.ndigits);
    endtask

    task automatic test_abc();
        pulse_clr(1); m_clr();
        press(4'hA, 4, 6); m_digit(4'hA);
        press(4'hB, 2, 6); m_digit(4'hB);
        press(4'hC, 7, 6); m_digit(4'hC);
        @(negedge hz100);
        checks++; if (de.value !== exp_value()) begin failures++; $display("FAIL abc_value got=%h exp=%h", de.value, exp_value()); end
        checks++; if (de.ndigits !== 4'(q.size())) begin failures++; $display("FAIL abc_ndigits got=%0d exp=%0d", de.ndigits, q.size()); end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (ss_obs[n] !== exp_ss(n)) begin failures++; $display("FAIL abc_ss%0d got=%h exp=%h", n, ss_obs[n], exp_ss(n)); end
        end
        $display("txn abc value=%h ndigits=%0d", de.value, de.ndigits);
    endtask

    task automatic test_bounce();
        logic [11:0] pat = 12'b1010_0100_0000;  // MSB first: 1,0,1,0,0,1,0,0,0,0,0,0
        pulse_clr(1); m_clr();
        @(posedge hz100); #1 de.code = 4'h2;
        for (int i = 11; i >= 0; i--) begin
            de.strobe = pat[i];
            @(posedge hz100); #1;
        end
        de.strobe = 1'b0;
        repeat (4) @(posedge hz100);
        m_digit(4'h2);
        @(negedge hz100);
        checks++; if (de.ndigits !== 4'(q.size())) begin failures++; $display("FAIL bounce_ndigits got=%0d exp=%0d", de.ndigits, q.size()); end
        checks++; if (de.value !== exp_value()) begin failures++; $display("FAIL bounce_value got=%h exp=%h", de.value, exp_value()); end
        $display("txn bounce value=%h ndigits=%0d", de.value, de.ndigits);
    endtask

    task automatic test_overflow();
        pulse_clr(2); m_clr();
        for (int d = 1; d <= 9; d++) begin
            press(4'(d), 3, 6);
            m_digit(4'(d));
        end
        @(negedge hz100);
        checks++; if (de.value !== exp_value()) begin failures++; $display("FAIL ovf_value got=%h exp=%h", de.value, exp_value()); end
        checks++; if (de.ndigits !== 4'(q.size())) begin failures++; $display("FAIL ovf_ndigits got=%0d exp=%0d", de.ndigits, q.size()); end
        checks++; if (de.err !== m_err) begin failures++; $display("FAIL ovf_err got=%b exp=%b", de.err, m_err); end
        checks++; if (ss_obs[0] !== exp_ss(0)) begin failures++; $display("FAIL ovf_ss0 got=%h exp=%h", ss_obs[0], exp_ss(0)); end
        $display("txn overflow value=%h ndigits=%0d err=%b", de.value, de.ndigits, de.err);
        pulse_bksp(2); m_bksp();
        @(negedge hz100);
        checks++; if (de.value !== exp_value()) begin failures++; $display("FAIL bksp_value got=%h exp=%h", de.value, exp_value()); end
        checks++; if (de.ndigits !== 4'(q.size())) begin failures++; $display("FAIL bksp_ndigits got=%0d exp=%0d", de.ndigits, q.size()); end
        checks++; if (de.err !== m_err) begin failures++; $display("FAIL bksp_err got=%b exp=%b", de.err, m_err); end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (ss_obs[n] !== exp_ss(n)) begin failures++; $display("FAIL bksp_ss%0d got=%h exp=%h", n, ss_obs[n], exp_ss(n)); end
        end
        $display("txn bksp value=%h ndigits=%0d err=%b", de.value, de.ndigits, de.err);
    endtask

    task automatic test_simultaneous();
        press(4'h4, 2, 6); m_digit(4'h4);
        @(posedge hz100); #1;
        de.clr = 1'b1; de.bksp = 1'b1; de.strobe = 1'b1; de.code = 4'h7;
        m_clr();
        repeat (12) @(posedge hz100);
        @(negedge hz100);
        checks++; if (de.ndigits !== 4'(q.size())) begin failures++; $display("FAIL simul_ndigits got=%0d exp=%0d", de.ndigits, q.size()); end
        checks++; if (de.value !== exp_value()) begin failures++; $display("FAIL simul_value got=%h exp=%h", de.value, exp_value()); end
        @(posedge hz100); #1;
        de.clr = 1'b0; de.bksp = 1'b0; de.strobe = 1'b0;
        repeat (6) @(posedge hz100);
        press(4'h3, 2, 6); m_digit(4'h3);
        @(negedge hz100);
        checks++; if (de.value !== exp_value()) begin failures++; $display("FAIL simul_after got=%h exp=%h", de.value, exp_value()); end
        $display("txn simultaneous value=%h ndigits=%0d", de.value, de.ndigits);
    endtask

    task automatic test_bksp_empty();
        pulse_clr(1); m_clr();
        pulse_bksp(1); m_bksp();
        @(negedge hz100);
        checks++; if (de.ndigits !== 4'd0) begin failures++; $display("FAIL empty_ndigits got=%0d exp=0", de.ndigits); end
        checks++; if (de.value !== 32'h0) begin failures++; $display("FAIL empty_value got=%h exp=0", de.value); end
        checks++; if (ss_obs[0] !== exp_ss(0)) begin failures++; $display("FAIL empty_ss0 got=%h exp=%h", ss_obs[0], exp_ss(0)); end
        $display("txn bksp_empty value=%h ndigits=%0d", de.value, de.ndigits);
    endtask

    task automatic test_reset_midpress();
        @(posedge hz100); #1 de.code = 4'h5; de.strobe = 1'b1;
        repeat (4) @(posedge hz100);
        #1 reset = 1'b1;
        repeat (2) @(posedge hz100);
        #1 reset = 1'b0;
        m_clr(); m_digit(4'h5);
        repeat (8) @(posedge hz100);
        #1 de.strobe = 1'b0;
        repeat (6) @(posedge hz100);
        @(negedge hz100);
        checks++; if (de.value !== exp_value()) begin failures++; $display("FAIL midpress_value got=%h exp=%h", de.value, exp_value()); end
        checks++; if (de.ndigits !== 4'(q.size())) begin failures++; $display("FAIL midpress_ndigits got=%0d exp=%0d", de.ndigits, q.size()); end
        $display("txn reset_midpress value=%h ndigits=%0d", de.value, de.ndigits);
    endtask

    task automatic test_random();
        int op;
        logic [3:0] d;
        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 9);
            if (op < 7) begin
                d = 4'($urandom_range(0, 15));
                press(d, $urandom_range(1, 5), 6);
                m_digit(d);
            end else if (op < 9) begin
                pulse_bksp($urandom_range(1, 3));
                m_bksp();
            end else begin
                pulse_clr($urandom_range(1, 3));
                m_clr();
            end
            @(negedge hz100);
            checks++; if (de.value !== exp_value()) begin failures++; $display("FAIL rand%0d_value got=%h exp=%h", t, de.value, exp_value()); end
            checks++; if (de.ndigits !== 4'(q.size())) begin failures++; $display("FAIL rand%0d_ndigits got=%0d exp=%0d", t, de.ndigits, q.size()); end
            checks++; if (de.err !== m_err) begin failures++; $display("FAIL rand%0d_err got=%b exp=%b", t, de.err, m_err); end
            for (int n = 0; n < 8; n++) begin
                checks++;
                if (ss_obs[n] !== exp_ss(n)) begin failures++; $display("FAIL rand%0d_ss%0d got=%h exp=%h", t, n, ss_obs[n], exp_ss(n)); end
            end
            $display("txn %0d op=%0d value=%h ndigits=%0d err=%b", t, op, de.value, de.ndigits, de.err);
        end
    endtask

    initial begin
        de.code = 4'h0; de.strobe = 1'b0; de.bksp = 1'b0; de.clr = 1'b0;
        m_err = 1'b0;
        test_reset();
        test_latency();
        test_abc();
        test_bounce();
        test_overflow();
        test_simultaneous();
        test_bksp_empty();
        test_reset_midpress();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
